softmax_vec_reader: RTL and testbench
=====================================

# softmax_vec_reader

Read-side controller for the softmax input FIFO. On a `start` pulse it pops exactly `LEN` elements from a FIFO with registered read data, which appear one cycle after `rd_en`. It presents the elements in order on a valid/ready stream to the softmax datapath and tracks the running signed maximum of the vector for the max-subtraction stage. It sits between the FIFO's read port and the exponent pipeline.

## Interface
Parameters:
- `DW`, 16, element width, two's-complement signed
- `LEN`, 32, elements per vector; must be ≥ 2
- `IW`, `$clog2(LEN)`, index width (derived; not to be overridden)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  begin one vector read; sampled only in IDLE
- `fifo_empty`  in  1  FIFO empty flag
- `fifo_rd_en`  out  1  FIFO pop request
- `fifo_data`  in  DW  FIFO read data, valid the cycle after an accepted pop
- `m_valid`  out  1  stream data valid
- `m_ready`  in  1  downstream accepts
- `m_data`  out  DW  element
- `m_idx`  out  IW  element index, 0..LEN-1
- `m_last`  out  1  high with element LEN-1
- `busy`  out  1  high in RUN and DONE
- `done`  out  1  one-cycle pulse after the last handshake
- `max_out`  out  DW  signed max of the vector; stable from `done` until the next `start`

## Operation
- The FSM has three states: IDLE, RUN, DONE.
- IDLE → RUN on `start`:
  - clear the issue count, the delivered count and the skid buffer
  - set `max_out` ← most-negative value (1 followed by DW-1 zeros)
- RUN: pops, captures and streams elements. RUN → DONE on the handshake (`m_valid && m_ready`) of the element with `m_idx == LEN-1`.
- DONE: `done` = 1 for exactly 1 cycle, then the FSM returns to IDLE. `start` in DONE is ignored.
- `start` in RUN is ignored.
- Pop rule, combinational from registered state:
  - `fifo_rd_en` = RUN && !`fifo_empty` && issued < LEN && (buffered + inflight) < 2
  - inflight = pop issued last cycle, not yet captured
  - buffered = entries in the 2-entry skid buffer
- Capture: the cycle after a pop, `fifo_data` is written to the buffer tail.
- Output:
  - `m_data` shows the buffer head
  - `m_valid` = buffered > 0
  - a handshake pops the head, increments `m_idx`, and updates `max_out` ← max(`max_out`, `m_data`) using a signed compare
- A simultaneous capture and handshake keeps the occupancy unchanged.
- The pop counter never exceeds LEN: no extra FIFO reads across vectors.
- `m_last` = `m_valid` && `m_idx == LEN-1`.
- Reset values:
  - state IDLE
  - `fifo_rd_en`, `m_valid`, `m_last`, `busy`, `done` = 0
  - `m_idx` = 0, `m_data` = 0
  - `max_out` = most-negative value
  - buffer flushed
- Reset mid-vector:
  - everything returns to the reset values on the next cycle
  - any in-flight read is discarded
  - FIFO contents and pointers are untouched (the FIFO has its own reset)

## Timing
- `start` is sampled high at cycle t. `busy` = 1 and the FSM is in RUN from t+1.
- The earliest `fifo_rd_en` is at t+1 (if not empty). The first `m_valid` is at t+2.
- Latency from pop to `m_valid` is 1 cycle. With `m_ready` = 1 and the FIFO non-empty, throughput is 1 element/cycle with no bubbles.
- A vector with no stalls:
  - pops at t+1..t+LEN
  - handshakes at t+2..t+LEN+1
  - `done` at t+LEN+2
  - IDLE at t+LEN+3
- `max_out` includes the last element in the cycle `done` is high.
- `fifo_rd_en` never asserts while `fifo_empty` = 1, in IDLE, or in DONE.
- Backpressure:
  - `m_data`, `m_idx` and `m_last` hold stable while `m_valid && !m_ready`
  - at most 2 elements are buffered, plus 0 in flight when the buffer is full

## Test plan
- LEN=4, FIFO holds 5, -3, 12, 7, `m_ready`=1, `start` at cycle 0:
  - pops at cycles 1-4
  - `m_data` 5, -3, 12, 7 at cycles 2-5, with `m_last` only at cycle 5
  - `done` at cycle 6, `max_out`=12
- Same data, `m_ready` low at cycles 3-5:
  - `m_data`=-3 held stable during the stall
  - `fifo_rd_en` deasserts once buffered+inflight=2
  - order 5, -3, 12, 7 with no loss or duplicates
- FIFO empty at cycles 2-4:
  - no `fifo_rd_en` while empty
  - `m_valid` gaps, order preserved
  - exactly 4 pops total
- Vector -8, -1, -5, -20 → `max_out`=-1 (checks the signed compare and the most-negative init).
- `start` re-pulsed in RUN and in DONE → ignored, `m_idx` continues, exactly LEN pops.
- `rst` at cycle 3 with 1 element buffered and 1 in flight:
  - next cycle `m_valid`=0, `busy`=0, `fifo_rd_en`=0
  - a new `start` streams the remaining FIFO data starting at `m_idx`=0

Source files
------------

// File: rtl/softmax_vec_reader.sv
// Read-side controller for the softmax input FIFO: pops one LEN-element vector,
// streams it over valid/ready through a 2-entry skid buffer and tracks its signed max.
module softmax_vec_reader #(
   parameter int unsigned DW  = 16,
   parameter int unsigned LEN = 32,
   parameter int unsigned IW  = $clog2(LEN)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          fifo_empty,
   output logic          fifo_rd_en,
   input  logic [DW-1:0] fifo_data,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [DW-1:0] m_data,
   output logic [IW-1:0] m_idx,
   output logic          m_last,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] max_out
);

   localparam int unsigned   CW       = $clog2(LEN + 1);
   localparam logic [CW-1:0] LEN_C    = CW'(LEN);
   localparam logic [IW-1:0] LAST_IDX = IW'(LEN - 1);
   localparam logic [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] issued_q, issued_d;
   logic          inflight_q, inflight_d;
   logic [1:0]    cnt_q, cnt_d;
   logic [DW-1:0] buf0_q, buf0_d;
   logic [DW-1:0] buf1_q, buf1_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [DW-1:0] max_q, max_d;

   logic          head_valid;
   logic [DW-1:0] head;
   logic [1:0]    occ;
   logic          hs;

   // The word returning from the FIFO is presented directly when the buffer is
   // empty, giving one-cycle pop-to-valid latency without an extra register stage.
   always_comb begin
      head_valid = (cnt_q != 2'd0) || inflight_q;
      head       = (cnt_q == 2'd0 && inflight_q) ? fifo_data : buf0_q;
      occ        = cnt_q + 2'(inflight_q);
      hs         = (state_q == S_RUN) && head_valid && m_ready;
      fifo_rd_en = (state_q == S_RUN) && !fifo_empty && (issued_q < LEN_C) && (occ < 2'd2);
   end

   assign m_valid = head_valid;
   assign m_data  = head;
   assign m_idx   = idx_q;
   assign m_last  = head_valid && (idx_q == LAST_IDX);
   assign busy    = (state_q != S_IDLE);
   assign done    = (state_q == S_DONE);
   assign max_out = max_q;

   always_comb begin
      state_d    = state_q;
      issued_d   = issued_q;
      inflight_d = fifo_rd_en;
      cnt_d      = cnt_q;
      buf0_d     = buf0_q;
      buf1_d     = buf1_q;
      idx_d      = idx_q;
      max_d      = max_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_RUN;
               issued_d = '0;
               cnt_d    = '0;
               idx_d    = '0;
               max_d    = MOST_NEG;
            end
         end
         S_RUN: begin
            issued_d = issued_q + CW'(fifo_rd_en);
            case ({inflight_q, hs})
               2'b10: begin
                  if (cnt_q == 2'd0) buf0_d = fifo_data;
                  else               buf1_d = fifo_data;
                  cnt_d = cnt_q + 2'd1;
               end
               2'b01: begin
                  buf0_d = buf1_q;
                  cnt_d  = cnt_q - 2'd1;
               end
               2'b11: begin
                  // Occupancy unchanged; with an empty buffer the arriving word was the head.
                  if (cnt_q == 2'd1) begin
                     buf0_d = fifo_data;
                  end else if (cnt_q == 2'd2) begin
                     buf0_d = buf1_q;
                     buf1_d = fifo_data;
                  end
               end
               default: ;
            endcase
            if (hs) begin
               if ($signed(head) > $signed(max_q)) max_d = head;
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  state_d = S_DONE;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         issued_q   <= '0;
         inflight_q <= 1'b0;
         cnt_q      <= '0;
         buf0_q     <= '0;
         buf1_q     <= '0;
         idx_q      <= '0;
         max_q      <= MOST_NEG;
      end else begin
         state_q    <= state_d;
         issued_q   <= issued_d;
         inflight_q <= inflight_d;
         cnt_q      <= cnt_d;
         buf0_q     <= buf0_d;
         buf1_q     <= buf1_d;
         idx_q      <= idx_d;
         max_q      <= max_d;
      end
   end

endmodule

// File: tb/tb_softmax_vec_reader.sv
// Self-checking bench for softmax_vec_reader: FIFO model plus a vector-level
// reference (expected stream, outstanding count, running max) checked every cycle.
module tb_softmax_vec_reader;

   localparam int unsigned DW  = 16;
   localparam int unsigned LEN = 4;
   localparam int unsigned IW  = $clog2(LEN);
   localparam logic [DW-1:0] MOST_NEG = 16'h8000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          fifo_empty = 1'b1;
   logic          fifo_rd_en;
   logic [DW-1:0] fifo_data = '0;
   logic          m_valid;
   logic          m_ready = 1'b1;
   logic [DW-1:0] m_data;
   logic [IW-1:0] m_idx;
   logic          m_last;
   logic          busy;
   logic          done;
   logic [DW-1:0] max_out;

   always #5 clk = ~clk;

   softmax_vec_reader #(.DW(DW), .LEN(LEN)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .fifo_empty (fifo_empty),
      .fifo_rd_en (fifo_rd_en),
      .fifo_data  (fifo_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_idx      (m_idx),
      .m_last     (m_last),
      .busy       (busy),
      .done       (done),
      .max_out    (max_out)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // FIFO model and next-cycle input values
   logic [DW-1:0] fifo_q[$];
   bit pop_pend = 1'b0;
   bit nx_rst = 1'b1, nx_start = 1'b0, nx_ready = 1'b1, nx_force_empty = 1'b0;

   // Reference model of the vector in progress
   bit            vec_active = 1'b0, act_pend = 1'b0, rst_pend = 1'b1, done_due = 1'b0;
   int            pop_cnt = 0, hs_cnt = 0;
   logic [DW-1:0] exp_v[LEN];
   logic [DW-1:0] exp_max;
   logic [DW-1:0] run_max = MOST_NEG;

   task automatic monitor();
      int outst;
      if (rst_pend) begin
         check("rst_valid", 32'(m_valid), 32'd0);
         check("rst_busy",  32'(busy), 32'd0);
         check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
         check("rst_done",  32'(done), 32'd0);
         check("rst_idx",   32'(m_idx), 32'd0);
         check("rst_data",  32'(m_data), 32'd0);
         check("rst_max",   32'(max_out), 32'(MOST_NEG));
         vec_active = 1'b0; act_pend = 1'b0; done_due = 1'b0;
         pop_cnt = 0; hs_cnt = 0; run_max = MOST_NEG;
      end
      rst_pend = rst;
      if (act_pend) begin
         act_pend = 1'b0; vec_active = 1'b1;
         pop_cnt = 0; hs_cnt = 0; run_max = MOST_NEG;
         for (int i = 0; i < LEN; i++) exp_v[i] = fifo_q[i];
         exp_max = exp_v[0];
         for (int i = 1; i < LEN; i++)
            if ($signed(exp_v[i]) > $signed(exp_max)) exp_max = exp_v[i];
      end
      outst = pop_cnt - hs_cnt;
      check("busy",    32'(busy), 32'(vec_active));
      check("done",    32'(done), 32'(done_due));
      check("valid",   32'(m_valid), 32'(outst > 0));
      check("last",    32'(m_last), 32'(outst > 0 && hs_cnt == LEN - 1));
      check("run_max", 32'(max_out), 32'(run_max));
      if (fifo_rd_en)
         check("rd_guard", 32'(fifo_empty || !vec_active || done_due || outst >= 2 || pop_cnt >= LEN), 32'd0);
      if (m_valid && vec_active && hs_cnt < LEN) begin
         check("data", 32'(m_data), 32'(exp_v[hs_cnt]));
         check("idx",  32'(m_idx), 32'(hs_cnt));
      end
      if (start && !vec_active && !rst) act_pend = 1'b1;
      if (done_due) begin
         check("done_max", 32'(max_out), 32'(exp_max));
         check("pops",     32'(pop_cnt), 32'(LEN));
         vec_active = 1'b0; done_due = 1'b0;
      end else if (m_valid && m_ready && vec_active && hs_cnt < LEN) begin
         if ($signed(exp_v[hs_cnt]) > $signed(run_max)) run_max = exp_v[hs_cnt];
         hs_cnt++;
         if (hs_cnt == LEN) done_due = 1'b1;
      end
      if (fifo_rd_en && !fifo_empty && vec_active) pop_cnt++;
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      if (pop_pend) begin
         fifo_data = fifo_q.pop_front();
         pop_pend  = 1'b0;
      end
      rst        = nx_rst;
      start      = nx_start;
      m_ready    = nx_ready;
      fifo_empty = nx_force_empty || (fifo_q.size() == 0);
      @(negedge clk);
      monitor();
      pop_pend = fifo_rd_en && !fifo_empty;
   endtask

   task automatic push4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] c, input logic [DW-1:0] d);
      fifo_q.push_back(a); fifo_q.push_back(b); fifo_q.push_back(c); fifo_q.push_back(d);
   endtask

   // start sampled in cycle k=0; masks give per-cycle input overrides for k>=1
   task automatic run_profile(input logic [15:0] ready_lo, input logic [15:0] empty_m,
                              input logic [15:0] start_m, input logic [15:0] rst_m,
                              input int n, input bit exact);
      nx_start = 1'b1;
      cycle();
      for (int k = 1; k <= n; k++) begin
         nx_ready       = !ready_lo[k];
         nx_force_empty = empty_m[k];
         nx_start       = start_m[k];
         nx_rst         = rst_m[k];
         cycle();
         if (exact) begin
            check("nostall_rd", 32'(fifo_rd_en), 32'(k <= LEN));
            check("nostall_hs", 32'(m_valid && m_ready), 32'(k >= 2 && k <= LEN + 1));
         end
      end
      nx_ready = 1'b1; nx_force_empty = 1'b0; nx_start = 1'b0; nx_rst = 1'b0;
      cycle();
      check("vec_end", 32'(vec_active || act_pend), 32'd0);
   endtask

   task automatic run_vec(input int ready_pct, input int empty_pct, input int start_pct);
      int guard = 0;
      nx_start = 1'b1;
      cycle();
      nx_start = 1'b0;
      do begin
         nx_ready       = ($urandom_range(0, 99) < ready_pct);
         nx_force_empty = ($urandom_range(0, 99) < empty_pct);
         nx_start       = vec_active && ($urandom_range(0, 99) < start_pct);
         cycle();
         guard++;
      end while ((vec_active || act_pend) && guard < 300);
      check("timeout", 32'(vec_active || act_pend), 32'd0);
      nx_start = 1'b0; nx_ready = 1'b1; nx_force_empty = 1'b0;
      cycle();
   endtask

   initial begin
      cycle();
      cycle();
      nx_rst = 1'b0;
      cycle();

      push4(16'd5, 16'hFFFD, 16'd12, 16'd7);
      run_profile(16'h0000, 16'h0000, 16'h0000, 16'h0000, LEN + 3, 1'b1);
      push4(16'd5, 16'hFFFD, 16'd12, 16'd7);
      run_profile(16'h0038, 16'h0000, 16'h0000, 16'h0000, 11, 1'b0);
      push4(16'd5, 16'hFFFD, 16'd12, 16'd7);
      run_profile(16'h0000, 16'h001C, 16'h0000, 16'h0000, 11, 1'b0);
      push4(16'hFFF8, 16'hFFFF, 16'hFFFB, 16'hFFEC);
      run_profile(16'h0000, 16'h0000, 16'h0000, 16'h0000, LEN + 3, 1'b1);
      push4(16'h7FFF, 16'h8000, 16'd0, 16'h8001);
      run_profile(16'h0000, 16'h0000, 16'h004C, 16'h0000, LEN + 3, 1'b1);

      // reset with one element buffered and one in flight; leftovers form the next vector
      push4(16'd100, 16'd200, 16'd300, 16'd400);
      push4(16'd11, 16'hFF00, 16'd13, 16'd14);
      run_profile(16'h0004, 16'h0000, 16'h0000, 16'h0008, 4, 1'b0);
      run_profile(16'h0000, 16'h0000, 16'h0000, 16'h0000, LEN + 3, 1'b1);
      fifo_q.delete();
      pop_pend = 1'b0;

      for (int v = 0; v < 12; v++) begin
         for (int i = 0; i < LEN; i++) fifo_q.push_back(DW'($urandom_range(0, 65535)));
         run_vec(40 + 5 * v, (v % 3) * 15, 20);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
